// File: rtl/sprite_reg_writer.sv
// sprite_reg_writer
// -----------------
// Buffers (address, data) register updates from game logic and writes them
// onto the sprite engine register bus during vertical sync only, so sprite
// positions never change mid-frame. Entries become eligible only once a
// commit pulse has marked them.
//
// Handshake: an update is accepted on any rising clk edge where
// in_valid && in_ready. in_valid may be raised at any time. in_ready is
// combinational. It is high while the FIFO has room, and also when the head
// entry is popped in the same cycle.
//
// Ports
//   clk, reset             system clock, asynchronous active-high reset
//   in_valid/in_ready      update handshake
//   in_addr/in_data        update payload
//   commit                 marks every buffered entry (incl. one pushed now)
//   vga_vs                 active-low vertical sync, same clock domain
//   chipselect/write       registered bus strobes (always equal)
//   address/writedata      registered bus payload, held between writes
//   fifo_count             FIFO occupancy
//   cmt_count              committed entries not yet written
//   frame_done             pulses together with the last write of a burst
//   fsm_state              current FSM state (debug)
module sprite_reg_writer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              commit,
  input  logic              vga_vs,
  output logic              chipselect,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  output logic [CW-1:0]     fifo_count,
  output logic [CW-1:0]     cmt_count,
  output logic              frame_done,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  logic          vs_q;
  logic          vs_fall;
  logic          push, pop, last_pop;
  logic [CW-1:0] fifo_next, cmt_next;

  assign fsm_state = state;
  assign vs_fall   = vs_q && !vga_vs;

  // The first pop happens in the cycle the sync fall is seen. Because the bus
  // is registered, the first write then appears one cycle after the fall.
  assign pop = (cmt_count != '0) && !vga_vs &&
               ((state == DRAIN) || ((state == WAIT_VS) && vs_q));

  assign in_ready  = (fifo_count < CW'(DEPTH)) || pop;
  assign push      = in_valid && in_ready;
  assign fifo_next = fifo_count + CW'(push) - CW'(pop);
  // A commit snapshots the occupancy after this cycle's push/pop, so it also
  // extends a burst already in progress.
  assign cmt_next  = commit ? fifo_next : (cmt_count - CW'(pop));
  assign last_pop  = pop && (cmt_next == '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if ((cmt_count != '0) || commit) state_next = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_fall) state_next = last_pop ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (last_pop)               state_next = IDLE;
        else if (cmt_count == '0)   state_next = IDLE;
        // Sync ended early: the rest waits for the next frame.
        else if (vga_vs)            state_next = WAIT_VS;
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage carries no reset; occupancy and pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      vs_q       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cmt_count  <= '0;
      chipselect <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      vs_q       <= vga_vs;
      fifo_count <= fifo_next;
      cmt_count  <= cmt_next;
      chipselect <= pop;
      write      <= pop;
      frame_done <= last_pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        address   <= addr_mem[rd_ptr];
        writedata <= data_mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_sprite_reg_writer.sv
// tb_sprite_reg_writer
// --------------------
// Directed bench for sprite_reg_writer. A queue-based reference model of the
// buffered, commit-gated, vsync-released write stream is compared against
// every DUT output on each falling clk edge. Literal checks on the captured
// write log pin the model to hand-computed results.
module tb_sprite_reg_writer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              in_valid, in_ready, commit, vga_vs;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              chipselect, write, frame_done;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [CW-1:0]     fifo_count, cmt_count;
  logic [1:0]        fsm_state;

  sprite_reg_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .commit     (commit),
    .vga_vs     (vga_vs),
    .chipselect (chipselect),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .fifo_count (fifo_count),
    .cmt_count  (cmt_count),
    .frame_done (frame_done),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t exp_q[$];              // entries still buffered, in FIFO order
  int   m_cmt     = 0;         // committed entries not yet written
  bit   m_wait    = 0;         // armed, waiting for a sync fall
  bit   m_burst   = 0;         // writing during the current sync
  bit   m_vs_prev = 1;
  logic              m_cs   = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic              m_done = 1'b0;

  ent_t m_e;
  bit   m_p, m_push, m_last, m_fall;
  int   m_old;

  function automatic bit m_pop();
    return (m_cmt > 0) && !vga_vs && (m_burst || (m_wait && m_vs_prev));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_cmt = 0; m_wait = 0; m_burst = 0; m_vs_prev = 1;
      m_cs = 1'b0; m_addr = '0; m_data = '0; m_done = 1'b0;
    end else begin
      m_fall = m_vs_prev && !vga_vs;
      m_p    = m_pop();
      m_push = in_valid && ((exp_q.size() < DEPTH) || m_p);
      m_old  = m_cmt;
      m_cs   = m_p;
      if (m_p) begin
        m_e    = exp_q.pop_front();
        m_addr = m_e.a;
        m_data = m_e.d;
      end
      if (m_push) exp_q.push_back({in_addr, in_data});
      m_cmt  = commit ? exp_q.size() : (m_cmt - int'(m_p));
      m_last = m_p && (m_cmt == 0);
      m_done = m_last;
      if (m_burst) begin
        if (m_p) begin
          if (m_last) m_burst = 0;
        end else if (m_old == 0) begin
          m_burst = 0;
        end else if (vga_vs) begin
          m_burst = 0; m_wait = 1;
        end
      end else if (m_wait) begin
        if (m_fall) begin
          m_wait = 0;
          m_burst = !m_last;
        end
      end else if ((m_old != 0) || commit) begin
        m_wait = 1;
      end
      m_vs_prev = vga_vs;
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                c;
    logic              done;
    logic              rdy;
  } wr_t;

  wr_t wlog[$];
  int  n_done = 0;

  always @(negedge clk) begin
    chk("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
    chk("cmt_count",  64'(cmt_count),  64'(m_cmt));
    chk("chipselect", 64'(chipselect), 64'(m_cs));
    chk("write",      64'(write),      64'(m_cs));
    chk("address",    64'(address),    64'(m_addr));
    chk("writedata",  64'(writedata),  64'(m_data));
    chk("frame_done", 64'(frame_done), 64'(m_done));
    chk("in_ready",   64'(in_ready),   64'((exp_q.size() < DEPTH) || m_pop()));
    if (chipselect === 1'b1) wlog.push_back('{address, writedata, cyc, frame_done, in_ready});
    if (frame_done === 1'b1) n_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int d);
    in_valid = 1'b1;
    in_addr  = ADDR_W'(a);
    in_data  = DATA_W'(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic vsync(input int n_low);
    vga_vs = 1'b0;
    tick(n_low);
    vga_vs = 1'b1;
    tick(4);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200us;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  int k;
  int w;

  initial begin
    in_valid = 1'b0; commit = 1'b0; vga_vs = 1'b1;
    in_addr = '0; in_data = '0;
    tick(3);
    reset = 1'b0;
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_chipselect", 64'(chipselect), 64'd0);
    chk("rst_address",    64'(address),    64'd0);

    // 1: two entries, held off until the sync fall
    push(0, 120); push(1, 200); do_commit();
    tick(100);
    chk("t1_no_early_write", 64'(wlog.size()), 64'd0);
    k = cyc;
    vsync(10);
    chk("t1_nwrites",  64'(wlog.size()), 64'd2);
    chk("t1_w0_addr",  64'(wlog[0].a),   64'd0);
    chk("t1_w0_data",  64'(wlog[0].d),   64'd120);
    chk("t1_w0_cycle", 64'(wlog[0].c),   64'(k + 1));
    chk("t1_w0_done",  64'(wlog[0].done), 64'd0);
    chk("t1_w1_addr",  64'(wlog[1].a),   64'd1);
    chk("t1_w1_data",  64'(wlog[1].d),   64'd200);
    chk("t1_w1_cycle", 64'(wlog[1].c),   64'(k + 2));
    chk("t1_w1_done",  64'(wlog[1].done), 64'd1);
    chk("t1_cmt",      64'(cmt_count),   64'd0);
    chk("t1_ndone",    64'(n_done),      64'd1);

    // 2: uncommitted entries stay behind
    wlog.delete(); n_done = 0;
    for (int i = 0; i < 3; i++) push(10 + i, 1000 + i);
    do_commit();
    push(20, 2000); push(21, 2001);
    vsync(10);
    chk("t2_nwrites", 64'(wlog.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_addr", 64'(wlog[i].a), 64'(10 + i));
      chk("t2_data", 64'(wlog[i].d), 64'(1000 + i));
    end
    chk("t2_fifo", 64'(fifo_count), 64'd2);
    chk("t2_cmt",  64'(cmt_count),  64'd0);
    wlog.delete();
    do_commit();
    vsync(10);
    chk("t2b_nwrites", 64'(wlog.size()), 64'd2);
    chk("t2b_addr0",   64'(wlog[0].a),   64'd20);
    chk("t2b_addr1",   64'(wlog[1].a),   64'd21);
    chk("t2b_data1",   64'(wlog[1].d),   64'd2001);

    // 3: full FIFO
    for (int i = 0; i < 16; i++) push(100 + i, i * 7 + 3);
    chk("t3_full_ready", 64'(in_ready),   64'd0);
    chk("t3_full_count", 64'(fifo_count), 64'd16);
    push(511, 32'h0000dead);
    chk("t3_17th_ignored", 64'(fifo_count), 64'd16);
    wlog.delete(); n_done = 0;
    do_commit();
    vsync(20);
    chk("t3_nwrites", 64'(wlog.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t3_addr", 64'(wlog[i].a), 64'(100 + i));
      chk("t3_data", 64'(wlog[i].d), 64'(i * 7 + 3));
    end
    chk("t3_ready_after_pop", 64'(wlog[0].rdy), 64'd1);
    chk("t3_fifo_empty",      64'(fifo_count),  64'd0);

    // 4: short sync splits the burst
    wlog.delete(); n_done = 0;
    for (int i = 0; i < 10; i++) push(200 + i, 32'h5000 + i);
    do_commit();
    vsync(4);
    chk("t4_nwrites", 64'(wlog.size()), 64'd4);
    chk("t4_cmt",     64'(cmt_count),   64'd6);
    chk("t4_no_done", 64'(n_done),      64'd0);
    vsync(10);
    chk("t4_nwrites_total", 64'(wlog.size()), 64'd10);
    for (int i = 0; i < 10; i++) chk("t4_addr", 64'(wlog[i].a), 64'(200 + i));
    chk("t4_ndone",     64'(n_done),        64'd1);
    chk("t4_done_last", 64'(wlog[9].done),  64'd1);

    // 5: commit mid-burst extends it
    wlog.delete(); n_done = 0;
    for (int i = 0; i < 3; i++) push(300 + i, 3000 + i);
    do_commit();
    vga_vs = 1'b0;
    tick();
    in_valid = 1'b1; in_addr = 9'd310; in_data = 32'd3100;
    tick();
    in_addr = 9'd311; in_data = 32'd3110; commit = 1'b1;
    tick();
    in_valid = 1'b0; commit = 1'b0;
    tick(15);
    vga_vs = 1'b1;
    tick(4);
    chk("t5_nwrites", 64'(wlog.size()), 64'd5);
    chk("t5_addr0", 64'(wlog[0].a), 64'd300);
    chk("t5_addr2", 64'(wlog[2].a), 64'd302);
    chk("t5_addr3", 64'(wlog[3].a), 64'd310);
    chk("t5_addr4", 64'(wlog[4].a), 64'd311);
    chk("t5_data4", 64'(wlog[4].d), 64'd3110);
    for (int i = 1; i < 5; i++) chk("t5_gapless", 64'(wlog[i].c), 64'(wlog[0].c + i));
    chk("t5_ndone", 64'(n_done), 64'd1);

    // 6: reset on the 3rd write of a 5-write burst
    wlog.delete(); n_done = 0;
    for (int i = 0; i < 5; i++) push(400 + i, 4000 + i);
    do_commit();
    vga_vs = 1'b0;
    w = 0;
    while (wlog.size() < 2 && w < 50) begin
      @(posedge clk);
      w++;
    end
    chk("t6_burst_started", 64'(w < 50), 64'd1);
    #1;
    chk("t6_cs_before_reset", 64'(chipselect), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_cs",    64'(chipselect), 64'd0);
    chk("t6_rst_write", 64'(write),      64'd0);
    chk("t6_rst_addr",  64'(address),    64'd0);
    chk("t6_rst_data",  64'(writedata),  64'd0);
    chk("t6_rst_fifo",  64'(fifo_count), 64'd0);
    chk("t6_rst_cmt",   64'(cmt_count),  64'd0);
    chk("t6_rst_ready", 64'(in_ready),   64'd1);
    tick(2);
    reset = 1'b0;
    vga_vs = 1'b1;
    tick(5);
    wlog.delete();
    vsync(10);
    chk("t6_no_writes", 64'(wlog.size()), 64'd0);
    chk("t6_fifo",      64'(fifo_count),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
